// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, baud/parity encodings, error bit
// positions and the baud divider calculation used by both directions.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam int PERR_BIT      = 0;
    localparam int START_ERR_BIT = 1;
    localparam int STOP_ERR_BIT  = 2;

    // Clocks per 16x oversample tick, truncated.
    function automatic int baud_div(input int clk_freq, input logic [1:0] code);
        case (code)
            BAUD_2400: return clk_freq / (2400 * 16);
            BAUD_4800: return clk_freq / (4800 * 16);
            BAUD_9600: return clk_freq / (9600 * 16);
            default:   return clk_freq / (19200 * 16);
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO of {serr, perr, data} entries; a push while full
// is accepted only when a pop frees the head slot in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [9:0]    wdata,
    output logic [9:0]    rdata,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_rx_path.sv
// UART receive path: 2-flop synchronizer, 16x oversampling deframer with
// parity/stop checking, sticky status flags and a show-ahead RX FIFO.
module uart_rx_path
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DEPTH    = 8,
    parameter int CW       = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          rx,
    input  logic [1:0]    baud_rate,
    input  logic [1:0]    parity_type,
    input  logic          rx_pop,
    input  logic          clr_status,
    output logic [7:0]    rx_data,
    output logic [1:0]    rx_err,
    output logic          rx_valid,
    output logic          rx_full,
    output logic [CW-1:0] rx_count,
    output logic          rx_active_flag,
    output logic          rx_done_flag,
    output logic [2:0]    error_flag,
    output logic          overrun_flag
);
    localparam int DIV0 = baud_div(CLK_FREQ, BAUD_2400);
    localparam int DIV1 = baud_div(CLK_FREQ, BAUD_4800);
    localparam int DIV2 = baud_div(CLK_FREQ, BAUD_9600);
    localparam int DIV3 = baud_div(CLK_FREQ, BAUD_19200);
    localparam int TW   = $clog2(DIV0 + 1);

    logic          rx_m, rx_s;
    rx_state_t     state, state_n;
    logic [3:0]    sc;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          perr, par_en, par_bad, smp, push, start_err;
    logic [1:0]    baud_q, par_q;
    logic [TW-1:0] tcnt, div_m1;
    logic          tick, fifo_empty;
    logic [2:0]    err_set;
    logic [9:0]    rdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) {rx_m, rx_s} <= 2'b11;
        else          {rx_m, rx_s} <= {rx, rx_m};
    end

    always_comb begin
        case (baud_q)
            BAUD_2400: div_m1 = TW'(DIV0 - 1);
            BAUD_4800: div_m1 = TW'(DIV1 - 1);
            BAUD_9600: div_m1 = TW'(DIV2 - 1);
            default:   div_m1 = TW'(DIV3 - 1);
        endcase
    end

    assign tick    = (tcnt == div_m1);
    assign smp     = tick && (sc == 4'd15);
    assign par_en  = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
    // Odd parity wants an odd count of ones across data + parity bit.
    assign par_bad = (par_q == PAR_ODD) ? ~^{shreg, rx_s} : ^{shreg, rx_s};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n   = state;
        push      = 1'b0;
        start_err = 1'b0;
        case (state)
            IDLE:   if (!rx_s) state_n = START;
            START:  if (tick && sc == 4'd7) begin
                        if (rx_s) begin
                            start_err = 1'b1;
                            state_n   = IDLE;
                        end else begin
                            state_n   = DATA;
                        end
                    end
            DATA:   if (smp && idx == 3'd7) state_n = par_en ? PARITY : STOP;
            PARITY: if (smp) state_n = STOP;
            STOP:   if (smp) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end
            default: state_n = IDLE;
        endcase
        err_set                = '0;
        err_set[PERR_BIT]      = push & perr;
        err_set[START_ERR_BIT] = start_err;
        err_set[STOP_ERR_BIT]  = push & ~rx_s;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tcnt         <= '0;
            sc           <= '0;
            idx          <= '0;
            shreg        <= '0;
            perr         <= 1'b0;
            baud_q       <= BAUD_2400;
            par_q        <= PAR_NONE;
            rx_done_flag <= 1'b0;
            error_flag   <= '0;
            overrun_flag <= 1'b0;
        end else begin
            // Realign the oversample phase to the falling edge of the start bit.
            if ((state == IDLE && !rx_s) || tick) tcnt <= '0;
            else                                  tcnt <= tcnt + 1'b1;

            if (state == IDLE) sc <= '0;
            else if (tick)     sc <= (state == START && sc == 4'd7) ? 4'd0 : sc + 4'd1;

            if (state != DATA) idx <= '0;
            else if (smp)      idx <= idx + 3'd1;

            if (state == DATA && smp) shreg <= {rx_s, shreg[7:1]};

            if (state == START)                 perr <= 1'b0;
            else if (state == PARITY && smp)    perr <= par_bad;

            if (state == IDLE && !rx_s) begin
                baud_q <= baud_rate;
                par_q  <= parity_type;
            end

            rx_done_flag <= push;
            error_flag   <= (clr_status ? 3'b000 : error_flag) | err_set;
            overrun_flag <= (clr_status ? 1'b0 : overrun_flag) | (push & rx_full & ~rx_pop);
        end
    end

    uart_rx_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (rx_pop),
        .wdata   ({~rx_s, perr, shreg}),
        .rdata   (rdata),
        .empty   (fifo_empty),
        .full    (rx_full),
        .count   (rx_count)
    );

    assign rx_data        = rdata[7:0];
    assign rx_err         = rdata[9:8];
    assign rx_valid       = ~fifo_empty;
    assign rx_active_flag = (state != IDLE);

endmodule
